usrt_tx: RTL
============

Name: usrt_tx

Overview:
Serial transmitter directly downstream of the status register. It consumes the status register's bit-period count (o_Baud) and parity setting (o_Parity), accepts bytes over a valid/ready handshake, and shifts each out on a single line: 1 start, 8 data LSB-first, optional even parity, 1 stop. A one-entry holding buffer lets the next byte be queued while the current frame is shifting, so back-to-back frames have no idle gap.

Parameters:
DATA_BITS, 8, data bits per frame; fixed at 8 for this block.
BAUD_W, 14, width of the bit-period input; must match the status register's o_Baud width.

Ports:
i_Pclk  input  1  system clock; all logic on the rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Baud  input  14  clock cycles per serial bit (status register o_Baud).
i_Parity  input  1  1 = append an even-parity bit (status register o_Parity).
i_TxValid  input  1  upstream byte valid.
i_TxData  input  8  byte to send.
o_TxReady  output  1  holding buffer empty; a byte can be accepted.
o_Tx  output  1  serial line, registered, idles high.
o_Busy  output  1  frame in progress (FSM not IDLE).
o_Done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset values (synchronous): o_Tx=1, o_Busy=0, o_Done=0, buffer empty, so o_TxReady=1 after the first reset edge. State = IDLE, counters = 0.
- Reset mid-frame: the frame is aborted and the buffered byte is discarded. o_Tx returns high at the reset edge.
- Handshake:
  - A byte is accepted at the edge where i_TxValid and o_TxReady are both 1; it is written to the holding buffer.
  - o_TxReady is the inverse of the buffer-valid register. It stays low during the cycle the buffer is drained, so there is no same-cycle drain and refill.
  - i_TxData is ignored while i_TxValid=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START:
  - Taken at the first edge where the buffer is valid.
  - At that edge: load the buffer into the shift register, clear the buffer, and latch i_Baud and i_Parity into frame-local registers.
  - i_Baud/i_Parity changes during a frame have no effect until the next frame's load.
- Bit timing: each bit lasts P cycles, where P = latched i_Baud, with 0 treated as 1. A down-counter reloads with P-1 on entering each bit; the bit ends when the counter reaches 0.
- Line levels:
  - START drives 0.
  - DATA drives shift[0], shifting right each bit; 8 bits, counted by a 3-bit index.
  - PARITY drives XOR of the 8 data bits (even parity). This state is skipped when the latched parity is 0.
  - STOP drives 1.
- Latency: for a handshake at edge N with the FSM idle, o_Tx falls at edge N+1.
- Frame length is 10·P cycles without parity and 11·P cycles with parity.
- End of STOP:
  - o_Done pulses high for exactly one cycle, starting at the edge that ends the stop bit.
  - If the buffer is valid at that edge, go directly to START (same load actions as IDLE -> START; no idle cycle).
  - Otherwise go to IDLE.
- o_Busy = (state != IDLE), registered alongside the state.

Decomposition:
- Shared package usrt_pkg: state enum (IDLE, START, DATA, PARITY, STOP), DATA_BITS, BAUD_W, and a bit-index width constant. The status register's baud constants move here too.
- One natural sub-module, usrt_baud_cnt: a loadable down-counter (load value P-1, output bit_end when the count is 0), reusable by the future receiver.

Test Plan:
- Reset, then i_Baud=4, i_Parity=0, send 0x55 -> o_Tx low at the edge after the handshake, then 4-cycle bits 0,1,0,1,0,1,0,1,0,1 (start, data LSB-first, stop); 40 cycles total; o_Done one pulse; o_Busy drops.
- i_Parity=1, i_Baud=3, send 0x07 -> parity bit 1. Repeat with 0x03 -> parity bit 0. Frames are 33 cycles.
- Back-to-back: 0xA5 then 0x3C with i_TxValid held high -> second byte accepted while the first shifts, o_TxReady low until the buffer drains, stop bit of the first byte followed immediately by the start bit of the second, two o_Done pulses 10·P cycles apart.
- Change i_Baud from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits, the next frame uses 8-cycle bits.
- Assert i_Reset during DATA with a byte buffered -> o_Tx=1, o_Busy=0, o_TxReady=1 after the reset edge; no o_Done; the buffered byte is never sent.
- i_Baud=0 -> 1-cycle bits, 10-cycle frame; no counter underflow or hang.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared types and constants for the USRT transmitter, receiver and status register.
package usrt_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BAUD_W    = 14;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);

  // Bit-period limits and reset value owned by the status register.
  localparam logic [BAUD_W-1:0] BAUD_MIN   = 14'd1;
  localparam logic [BAUD_W-1:0] BAUD_MAX   = 14'h3fff;
  localparam logic [BAUD_W-1:0] BAUD_RESET = 14'd434;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Counter reload for a bit period; a zero period behaves as one cycle.
  function automatic logic [BAUD_W-1:0] baud_reload(input logic [BAUD_W-1:0] baud);
    return (baud == '0) ? '0 : baud - 1'b1;
  endfunction

endpackage

// File: rtl/usrt_if.sv
// Byte valid/ready handshake into the USRT transmitter.
interface usrt_if
  import usrt_pkg::*;
();

  logic                 i_TxValid;
  logic [DATA_BITS-1:0] i_TxData;
  logic                 o_TxReady;

  modport master (output i_TxValid, output i_TxData, input o_TxReady);
  modport slave  (input i_TxValid, input i_TxData, output o_TxReady);

endinterface

// File: rtl/usrt_baud_cnt.sv
// Loadable bit-period down-counter; o_BitEnd marks the last cycle of a bit.
module usrt_baud_cnt #(
  parameter int unsigned BAUD_W = 14
) (
  input  logic              i_Pclk,
  input  logic              i_Reset,
  input  logic              i_Load,
  input  logic [BAUD_W-1:0] i_LoadVal,
  output logic              o_BitEnd
);

  logic [BAUD_W-1:0] count_q;

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      count_q <= '0;
    end else if (i_Load) begin
      count_q <= i_LoadVal;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign o_BitEnd = (count_q == '0);

endmodule

// File: rtl/usrt_tx.sv
// USRT serial transmitter: start, 8 data LSB-first, optional even parity, stop,
// with a one-entry holding buffer for gapless back-to-back frames.
module usrt_tx
  import usrt_pkg::*;
(
  input  logic              i_Pclk,
  input  logic              i_Reset,
  input  logic [BAUD_W-1:0] i_Baud,
  input  logic              i_Parity,
  usrt_if.slave             tx_if,
  output logic              o_Tx,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 buf_vld_q, buf_vld_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 done_q, done_d;

  logic                 cnt_load;
  logic [BAUD_W-1:0]    cnt_val;
  logic                 bit_end;
  logic                 load_frame;

  usrt_baud_cnt #(
    .BAUD_W (BAUD_W)
  ) u_baud_cnt (
    .i_Pclk    (i_Pclk),
    .i_Reset   (i_Reset),
    .i_Load    (cnt_load),
    .i_LoadVal (cnt_val),
    .o_BitEnd  (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    idx_d      = idx_q;
    baud_d     = baud_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = baud_q;
    load_frame = 1'b0;

    if (tx_if.i_TxValid && !buf_vld_q) begin
      buf_d     = tx_if.i_TxData;
      buf_vld_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        load_frame = buf_vld_q;
      end
      StStart: begin
        if (bit_end) begin
          state_d  = StData;
          idx_d    = '0;
          tx_d     = shift_q[0];
          cnt_load = 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          if (idx_q == IdxLast) begin
            state_d = par_en_q ? StParity : StStop;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d  = StStop;
          tx_d     = 1'b1;
          cnt_load = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (buf_vld_q) begin
            load_frame = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Frame-local copies of baud and parity are taken only here.
    if (load_frame) begin
      state_d   = StStart;
      shift_d   = buf_q;
      par_bit_d = ^buf_q;
      buf_vld_d = 1'b0;
      idx_d     = '0;
      baud_d    = baud_reload(i_Baud);
      par_en_d  = i_Parity;
      tx_d      = 1'b0;
      cnt_load  = 1'b1;
      cnt_val   = baud_reload(i_Baud);
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      idx_q     <= '0;
      baud_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      idx_q     <= idx_d;
      baud_q    <= baud_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= done_d;
    end
  end

  assign tx_if.o_TxReady = ~buf_vld_q;
  assign o_Tx            = tx_q;
  assign o_Busy          = busy_q;
  assign o_Done          = done_q;

endmodule
